// File: rtl/spi_blockread_ctrl.sv
// -----------------------------------------------------------------------------
// spi_blockread_ctrl
//   Reads one data block from an SDHC card through the SD SPI command/byte
//   engine. The controller sends CMD17, checks R1 and polls for the 0xFE start
//   token. It then packs the payload big-endian into 32-bit words for boot
//   memory and finally consumes the two CRC bytes.
//
// Optional build macro: SPI_RD_CRC16_EN
//   Defined   : the payload CRC16-CCITT is computed and compared with the
//               received CRC. A mismatch reports error code 5.
//   Undefined : the CRC bytes are read and discarded. No CRC logic is built.
//
// Ports
//   spi_clk_i / spi_rst_i  : clock, asynchronous active-low reset
//   init_done_i            : card initialisation finished
//   rd_req_i, rd_blk_i,    : start pulse, SDHC block address,
//   rd_base_i              :   first memory word address
//   rd_busy_o, rd_done_o,  : busy level, success pulse,
//   rd_err_o, err_code_o   :   failure pulse, held failure code
//   cmd_o, cmd_start_o     : command frame and launch pulse to the SPI core
//   cmd_done_i, r1_i       : command finished, R1 response
//   byte_req_o             : request one received byte (MOSI = 0xFF)
//   byte_valid_i, byte_i   : received byte strobe and value
//   mem_we_o, mem_addr_o,  : boot memory word write port
//   mem_data_o
//
// Error codes: 1 not initialised, 2 bad R1, 3 token timeout, 4 data error
//              token, 5 CRC mismatch, 6 command timeout.
// -----------------------------------------------------------------------------
module spi_blockread_ctrl #(
  parameter int BLOCK_BYTES   = 512,
  parameter int MEM_AW        = 16,
  parameter int TOKEN_TIMEOUT = 1024,
  parameter int CMD_TIMEOUT   = 65535
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              init_done_i,
  input  logic              rd_req_i,
  input  logic [31:0]       rd_blk_i,
  input  logic [MEM_AW-1:0] rd_base_i,
  output logic              rd_busy_o,
  output logic              rd_done_o,
  output logic              rd_err_o,
  output logic [2:0]        err_code_o,
  output logic [47:0]       cmd_o,
  output logic              cmd_start_o,
  input  logic              cmd_done_i,
  input  logic [7:0]        r1_i,
  output logic              byte_req_o,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEND_CMD   = 3'd1;
  localparam logic [2:0] S_WAIT_R1    = 3'd2;
  localparam logic [2:0] S_WAIT_TOKEN = 3'd3;
  localparam logic [2:0] S_READ_DATA  = 3'd4;
  localparam logic [2:0] S_READ_CRC   = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_ERROR      = 3'd7;

  // Terminal values of the shared counter in each phase.
  localparam logic [31:0] CMD_LAST  = 32'(CMD_TIMEOUT - 1);
  localparam logic [31:0] TOK_LAST  = 32'(TOKEN_TIMEOUT - 1);
  localparam logic [31:0] BYTE_LAST = 32'(BLOCK_BYTES - 1);

`ifdef SPI_RD_CRC16_EN
  // CRC16-CCITT (poly 0x1021), one byte per call, MSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q, crc_hi_d;
`endif

  logic [2:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;        // cycles in WAIT_R1, polls, byte index
  logic              pend_q, pend_d;      // one byte request outstanding
  logic [23:0]       word_q, word_d;      // first three bytes of the current word
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;
  logic [47:0]       cmd_q, cmd_d;
  logic              cmd_start_q, cmd_start_d;
  logic              byte_req_q, byte_req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              fail_s;
  logic [2:0]        fail_code_s;
  logic              ok_s;
  logic              rx_s;

  // A byte is only consumed while a request is outstanding.
  assign rx_s = pend_q & byte_valid_i;

  // Next-state and output-register logic of the read sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    cmd_d       = cmd_q;
    cmd_start_d = 1'b0;
    byte_req_d  = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    fail_s      = 1'b0;
    fail_code_s = 3'd0;
    ok_s        = 1'b0;
`ifdef SPI_RD_CRC16_EN
    crc_d       = crc_q;
    crc_hi_d    = crc_hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rd_req_i && init_done_i) begin
          cmd_d       = {8'h51, rd_blk_i, 8'hFF};
          cmd_start_d = 1'b1;
          waddr_d     = rd_base_i;
          busy_d      = 1'b1;
          cnt_d       = 32'd0;
          pend_d      = 1'b0;
`ifdef SPI_RD_CRC16_EN
          crc_d       = 16'h0000;
`endif
          state_d     = S_SEND_CMD;
        end else if (rd_req_i) begin
          err_d  = 1'b1;
          code_d = 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND_CMD: begin
        state_d = S_WAIT_R1;
      end
      S_WAIT_R1: begin
        if (cmd_done_i) begin
          if (r1_i == 8'h00) begin
            state_d    = S_WAIT_TOKEN;
            cnt_d      = 32'd0;
            byte_req_d = 1'b1;
            pend_d     = 1'b1;
          end else begin
            fail_s      = 1'b1;
            fail_code_s = 3'd2;
          end
        end else if (cnt_q == CMD_LAST) begin
          fail_s      = 1'b1;
          fail_code_s = 3'd6;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_TOKEN: begin
        if (rx_s) begin
          if (byte_i == 8'hFE) begin
            state_d    = S_READ_DATA;
            cnt_d      = 32'd0;
            byte_req_d = 1'b1;
          end else if (byte_i[7:4] == 4'h0) begin
            fail_s      = 1'b1;
            fail_code_s = 3'd4;
          end else if (cnt_q == TOK_LAST) begin
            fail_s      = 1'b1;
            fail_code_s = 3'd3;
          end else begin
            cnt_d      = cnt_q + 32'd1;
            byte_req_d = 1'b1;
          end
        end else begin
          state_d = S_WAIT_TOKEN;
        end
      end
      S_READ_DATA: begin
        if (rx_s) begin
          word_d     = {word_q[15:0], byte_i};
          byte_req_d = 1'b1;
`ifdef SPI_RD_CRC16_EN
          crc_d      = crc16_upd(crc_q, byte_i);
`endif
          // Fourth byte of a word completes it; write on the next cycle.
          if (cnt_q[1:0] == 2'b11) begin
            we_d    = 1'b1;
            addr_d  = waddr_q;
            data_d  = {word_q, byte_i};
            waddr_d = waddr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
          end else begin
            we_d = 1'b0;
          end
          if (cnt_q == BYTE_LAST) begin
            state_d = S_READ_CRC;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          state_d = S_READ_DATA;
        end
      end
      S_READ_CRC: begin
        if (rx_s) begin
          if (cnt_q == 32'd0) begin
`ifdef SPI_RD_CRC16_EN
            crc_hi_d   = byte_i;
`endif
            cnt_d      = 32'd1;
            byte_req_d = 1'b1;
          end else begin
`ifdef SPI_RD_CRC16_EN
            if ({crc_hi_q, byte_i} != crc_q) begin
              fail_s      = 1'b1;
              fail_code_s = 3'd5;
            end else begin
              ok_s = 1'b1;
            end
`else
            ok_s = 1'b1;
`endif
          end
        end else begin
          state_d = S_READ_CRC;
        end
      end
      S_DONE, S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Terminate the transfer; done/err pulse and busy drop land together.
    if (fail_s) begin
      err_d      = 1'b1;
      code_d     = fail_code_s;
      busy_d     = 1'b0;
      pend_d     = 1'b0;
      byte_req_d = 1'b0;
      state_d    = S_ERROR;
    end else if (ok_s) begin
      done_d     = 1'b1;
      code_d     = 3'd0;
      busy_d     = 1'b0;
      pend_d     = 1'b0;
      byte_req_d = 1'b0;
      state_d    = S_DONE;
    end else if (byte_req_d) begin
      pend_d = 1'b1;
    end else if (rx_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_d;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      pend_q      <= 1'b0;
      word_q      <= 24'd0;
      waddr_q     <= {MEM_AW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 3'd0;
      cmd_q       <= 48'd0;
      cmd_start_q <= 1'b0;
      byte_req_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {MEM_AW{1'b0}};
      data_q      <= 32'd0;
`ifdef SPI_RD_CRC16_EN
      crc_q       <= 16'h0000;
      crc_hi_q    <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      word_q      <= word_d;
      waddr_q     <= waddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
      cmd_q       <= cmd_d;
      cmd_start_q <= cmd_start_d;
      byte_req_q  <= byte_req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef SPI_RD_CRC16_EN
      crc_q       <= crc_d;
      crc_hi_q    <= crc_hi_d;
`endif
    end
  end

  assign rd_busy_o   = busy_q;
  assign rd_done_o   = done_q;
  assign rd_err_o    = err_q;
  assign err_code_o  = code_q;
  assign cmd_o       = cmd_q;
  assign cmd_start_o = cmd_start_q;
  assign byte_req_o  = byte_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;

endmodule

// File: tb/tb_spi_blockread_ctrl.sv
// Bench for spi_blockread_ctrl: a table of read scenarios is replayed
// against a behavioural card/SPI-core responder. A hand-written sequence
// covers a request while busy and a reset in the middle of a block.
module tb_spi_blockread_ctrl;

  logic        spi_clk_i = 1'b0;
  logic        spi_rst_i = 1'b0;
  logic        init_done_i = 1'b0;
  logic        rd_req_i = 1'b0;
  logic [31:0] rd_blk_i = 32'd0;
  logic [15:0] rd_base_i = 16'd0;
  logic        rd_busy_o, rd_done_o, rd_err_o;
  logic [2:0]  err_code_o;
  logic [47:0] cmd_o;
  logic        cmd_start_o;
  logic        cmd_done_i;
  logic [7:0]  r1_i;
  logic        byte_req_o;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_data_o;

  spi_blockread_ctrl #(
    .BLOCK_BYTES(512), .MEM_AW(16), .TOKEN_TIMEOUT(8), .CMD_TIMEOUT(16)
  ) dut (
    .spi_clk_i(spi_clk_i), .spi_rst_i(spi_rst_i), .init_done_i(init_done_i),
    .rd_req_i(rd_req_i), .rd_blk_i(rd_blk_i), .rd_base_i(rd_base_i),
    .rd_busy_o(rd_busy_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
    .err_code_o(err_code_o), .cmd_o(cmd_o), .cmd_start_o(cmd_start_o),
    .cmd_done_i(cmd_done_i), .r1_i(r1_i), .byte_req_o(byte_req_o),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
  );

  always #5 spi_clk_i = ~spi_clk_i;

  typedef struct {
    logic        init;
    logic [31:0] blk;
    logic [15:0] base;
    logic [7:0]  r1;
    logic        r1_never;
    int          nff;
    logic [7:0]  tok;
    logic        zero_pl;
    logic [15:0] crc;
    logic        exp_done;
    logic [2:0]  exp_code;
    int          exp_writes;
    int          exp_breq;
    logic [31:0] exp_first;
    logic [15:0] exp_last_addr;
    logic [31:0] exp_last;
  } vec_t;

  // Card configuration, written only by the main sequence.
  logic [7:0]  cfg_r1 = 8'h00;
  logic        cfg_r1_never = 1'b0;
  int          cfg_nff = 0;
  logic [7:0]  cfg_tok = 8'hFE;
  logic        cfg_zero = 1'b0;
  logic [15:0] cfg_crc = 16'h0000;

  // Responder-owned event counters and write records.
  int          n_cmd = 0, n_breq = 0, n_we = 0, n_done = 0, n_err = 0, n_busy_bad = 0;
  int          idx = 0, cmd_wait = 0;
  logic        first_pend = 1'b0;
  logic [15:0] first_addr = 16'd0, last_addr = 16'd0;
  logic [31:0] first_data = 32'd0, last_data = 32'd0;

  int total = 0;
  int bad = 0;

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [7:0] card_byte(input int bi);
    int p;
    if (bi < cfg_nff) return 8'hFF;
    if (bi == cfg_nff) return cfg_tok;
    p = bi - cfg_nff - 1;
    if (p < 512) return cfg_zero ? 8'h00 : 8'(p);
    if (p == 512) return cfg_crc[15:8];
    if (p == 513) return cfg_crc[7:0];
    return 8'hFF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Card / SPI core responder: one-cycle byte replies, R1 three cycles after launch.
  initial begin
    cmd_done_i = 1'b0; r1_i = 8'h00; byte_valid_i = 1'b0; byte_i = 8'h00;
    forever begin
      @(posedge spi_clk_i); #1;
      cmd_done_i = 1'b0;
      byte_valid_i = 1'b0;
      if (cmd_start_o) begin
        n_cmd++; idx = 0; cmd_wait = 3; first_pend = 1'b1;
      end else if (cmd_wait > 0) begin
        cmd_wait--;
        if (cmd_wait == 0 && !cfg_r1_never) begin
          cmd_done_i = 1'b1;
          r1_i = cfg_r1;
        end
      end
      if (byte_req_o) begin
        n_breq++;
        byte_valid_i = 1'b1;
        byte_i = card_byte(idx);
        idx++;
      end
      if (mem_we_o) begin
        n_we++;
        if (first_pend) begin
          first_addr = mem_addr_o; first_data = mem_data_o; first_pend = 1'b0;
        end
        last_addr = mem_addr_o; last_data = mem_data_o;
      end
      if (rd_done_o) begin
        n_done++;
        if (rd_busy_o) n_busy_bad++;
      end
      if (rd_err_o) n_err++;
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, 64'({rd_busy_o, rd_done_o, rd_err_o, cmd_start_o, byte_req_o, mem_we_o}), 64'd0);
    chk({nm, " code"}, 64'(err_code_o), 64'd0);
    chk({nm, " cmd"}, 64'(cmd_o), 64'd0);
    chk({nm, " mem"}, 64'({mem_addr_o, mem_data_o}), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int c0, b0, w0, d0, e0, bb0;
    bit fin;
    c0 = n_cmd; b0 = n_breq; w0 = n_we; d0 = n_done; e0 = n_err; bb0 = n_busy_bad;
    cfg_r1 = v.r1; cfg_r1_never = v.r1_never; cfg_nff = v.nff; cfg_tok = v.tok;
    cfg_zero = v.zero_pl; cfg_crc = v.crc;
    init_done_i = v.init; rd_blk_i = v.blk; rd_base_i = v.base;
    @(posedge spi_clk_i); #1;
    rd_req_i = 1'b1;
    @(posedge spi_clk_i); #1;
    rd_req_i = 1'b0;
    chk({nm, " busy start"}, 64'(rd_busy_o), 64'(v.init));
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(posedge spi_clk_i); #2;
      if ((n_done - d0) + (n_err - e0) > 0) fin = 1'b1;
    end
    chk({nm, " finished"}, 64'(fin), 64'd1);
    @(posedge spi_clk_i); #2;
    chk({nm, " done cnt"}, 64'(n_done - d0), 64'(v.exp_done));
    chk({nm, " err cnt"}, 64'(n_err - e0), 64'(!v.exp_done));
    chk({nm, " err code"}, 64'(err_code_o), 64'(v.exp_code));
    chk({nm, " writes"}, 64'(n_we - w0), 64'(v.exp_writes));
    chk({nm, " byte reqs"}, 64'(n_breq - b0), 64'(v.exp_breq));
    chk({nm, " cmd starts"}, 64'(n_cmd - c0), 64'(v.init));
    chk({nm, " busy end"}, 64'(rd_busy_o), 64'd0);
    chk({nm, " busy at done"}, 64'(n_busy_bad - bb0), 64'd0);
    if (v.init) chk({nm, " cmd frame"}, 64'(cmd_o), 64'({8'h51, v.blk, 8'hFF}));
    if (v.exp_writes > 0) begin
      chk({nm, " first addr"}, 64'(first_addr), 64'(v.base));
      chk({nm, " first data"}, 64'(first_data), 64'(v.exp_first));
      chk({nm, " last addr"}, 64'(last_addr), 64'(v.exp_last_addr));
      chk({nm, " last data"}, 64'(last_data), 64'(v.exp_last));
    end
  endtask

  vec_t vt[8];

  initial begin
    logic [15:0] crc_inc;
    int w0, c0, d0, e0;
    bit fin;
    crc_inc = 16'h0000;
    for (int i = 0; i < 512; i++) crc_inc = crc_ref(crc_inc, 8'(i));

    //         init  blk            base      r1     never nff      tok    zero  crc
    //         done  code writes breq first         last_addr last_data
    vt[0] = '{1'b0, 32'h00000010, 16'h0100, 8'h00, 1'b0, 2,       8'hFE, 1'b0, 16'h0000,
              1'b0, 3'd1, 0,     0,   32'h0,        16'h0,    32'h0};
    vt[1] = '{1'b1, 32'h00000010, 16'h0100, 8'h00, 1'b0, 2,       8'hFE, 1'b0, crc_inc,
              1'b1, 3'd0, 128,   517, 32'h00010203, 16'h017F, 32'hFCFDFEFF};
    vt[2] = '{1'b1, 32'hDEADBEEF, 16'h0100, 8'h04, 1'b0, 0,       8'hFE, 1'b0, 16'h0000,
              1'b0, 3'd2, 0,     0,   32'h0,        16'h0,    32'h0};
    vt[3] = '{1'b1, 32'h00000020, 16'h0100, 8'h00, 1'b0, 1000000, 8'hFE, 1'b0, 16'h0000,
              1'b0, 3'd3, 0,     8,   32'h0,        16'h0,    32'h0};
    vt[4] = '{1'b1, 32'h00000021, 16'h0100, 8'h00, 1'b0, 0,       8'h08, 1'b0, 16'h0000,
              1'b0, 3'd4, 0,     1,   32'h0,        16'h0,    32'h0};
    vt[5] = '{1'b1, 32'h00000022, 16'h0100, 8'h00, 1'b1, 0,       8'hFE, 1'b0, 16'h0000,
              1'b0, 3'd6, 0,     0,   32'h0,        16'h0,    32'h0};
    vt[6] = '{1'b1, 32'hFFFFFFFF, 16'hFFC0, 8'h00, 1'b0, 0,       8'hFE, 1'b1, 16'h0000,
              1'b1, 3'd0, 128,   515, 32'h0,        16'h003F, 32'h0};
`ifdef SPI_RD_CRC16_EN
    vt[7] = '{1'b1, 32'h00000040, 16'h2000, 8'h00, 1'b0, 0,       8'hFE, 1'b1, 16'h1234,
              1'b0, 3'd5, 128,   515, 32'h0,        16'h207F, 32'h0};
`else
    vt[7] = '{1'b1, 32'h00000040, 16'h2000, 8'h00, 1'b0, 0,       8'hFE, 1'b1, 16'h1234,
              1'b1, 3'd0, 128,   515, 32'h0,        16'h207F, 32'h0};
`endif

    // Reset state, then release away from the clock edge.
    #12;
    chk_zero("reset");
    @(posedge spi_clk_i); #3;
    spi_rst_i = 1'b1;
    @(posedge spi_clk_i); #1;
    chk_zero("after reset");

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Request while busy is ignored; reset after 200 payload bytes.
    w0 = n_we; c0 = n_cmd; d0 = n_done; e0 = n_err;
    cfg_r1 = 8'h00; cfg_r1_never = 1'b0; cfg_nff = 2; cfg_tok = 8'hFE; cfg_zero = 1'b0;
    init_done_i = 1'b1; rd_blk_i = 32'h00000010; rd_base_i = 16'h0100;
    @(posedge spi_clk_i); #1;
    rd_req_i = 1'b1;
    @(posedge spi_clk_i); #1;
    rd_req_i = 1'b0;
    repeat (20) @(posedge spi_clk_i);
    #1;
    rd_blk_i = 32'h00000099;
    rd_req_i = 1'b1;
    @(posedge spi_clk_i); #1;
    rd_req_i = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(posedge spi_clk_i); #1;
      if (n_we - w0 >= 50) fin = 1'b1;
    end
    chk("midblock reached", 64'(fin), 64'd1);
    chk("busy req ignored", 64'(n_cmd - c0), 64'd1);
    chk("midblock busy", 64'(rd_busy_o), 64'd1);
    #2;
    spi_rst_i = 1'b0;
    #1;
    chk_zero("async reset");
    repeat (3) @(posedge spi_clk_i);
    #3;
    spi_rst_i = 1'b1;
    repeat (2) @(posedge spi_clk_i);
    #2;
    chk("no pulse on reset", 64'((n_done - d0) + (n_err - e0)), 64'd0);
    run_vec(vt[1], "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
